// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: FSM states,
// per-stage control bundles and the hazard helper functions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [3:0] REG_ZERO = 4'h0;

  typedef struct packed {
    logic stall_im_id;
    logic stall_id_ex;
    logic stall_ex_dm;
    logic flush_im_id;
    logic flush_id_ex;
  } ctrl_t;

  // NOP-insertion patterns: a flush loads a NOP into that pipeline register.
  localparam ctrl_t CTRL_PASS      = 5'b00000;
  localparam ctrl_t CTRL_FREEZE    = 5'b11100;
  localparam ctrl_t CTRL_RESET     = 5'b11111;
  localparam ctrl_t CTRL_SQUASH    = 5'b00011;
  localparam ctrl_t CTRL_ID_BUBBLE = 5'b10001;
  localparam ctrl_t CTRL_IF_BUBBLE = 5'b10010;
  localparam ctrl_t CTRL_DRAIN     = 5'b10011;

  function automatic logic load_use(
    input logic       ld,
    input logic [3:0] dst,
    input logic [3:0] src0,
    input logic [3:0] src1,
    input logic       src0_vld,
    input logic       src1_vld
  );
    logic hit;
    hit = (src0_vld && (src0 == dst)) || (src1_vld && (src1 == dst));
    return ld && (dst != REG_ZERO) && hit;
  endfunction

  // Priority among the non-miss sources while the pipeline is free to issue.
  function automatic ctrl_t run_ctrl(
    input logic flow_change,
    input logic hlt,
    input logic luh,
    input logic i_rdy
  );
    ctrl_t result;
    if (flow_change) begin
      result = CTRL_SQUASH;
    end else if (hlt || luh) begin
      result = CTRL_ID_BUBBLE;
    end else if (!i_rdy) begin
      result = CTRL_IF_BUBBLE;
    end else begin
      result = CTRL_PASS;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush outputs of the hazard
// scheduler; slave is the scheduler side, master is the pipeline side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             i_rdy;
  logic             d_rdy;
  logic             dm_access_EX_DM;
  logic             ld_ID_EX;
  logic [3:0]       ld_dst_ID_EX;
  logic [3:0]       src0_IM_ID;
  logic [3:0]       src1_IM_ID;
  logic             src0_vld;
  logic             src1_vld;
  logic             flow_change_ID_EX;
  logic             hlt_ID_EX;
  logic             stall_IM_ID;
  logic             stall_ID_EX;
  logic             stall_EX_DM;
  logic             flush_IM_ID;
  logic             flush_ID_EX;
  logic             halted;
  logic             miss_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output i_rdy, d_rdy, dm_access_EX_DM, ld_ID_EX, ld_dst_ID_EX,
           src0_IM_ID, src1_IM_ID, src0_vld, src1_vld,
           flow_change_ID_EX, hlt_ID_EX,
    input  stall_IM_ID, stall_ID_EX, stall_EX_DM, flush_IM_ID, flush_ID_EX,
           halted, miss_err, stall_cnt
  );

  modport slave (
    input  i_rdy, d_rdy, dm_access_EX_DM, ld_ID_EX, ld_dst_ID_EX,
           src0_IM_ID, src1_IM_ID, src0_vld, src1_vld,
           flow_change_ID_EX, hlt_ID_EX,
    output stall_IM_ID, stall_ID_EX, stall_EX_DM, flush_IM_ID, flush_ID_EX,
           halted, miss_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates data/instruction
// misses, load-use hazards, flow changes and halt into per-stage controls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int TO_W  = $clog2(MISS_TIMEOUT + 1);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(MISS_TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [DRN_W-1:0] drain_q;
  logic [DRN_W-1:0] drain_d;
  logic             miss_err_q;
  logic             miss_err_d;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;
  logic             luh;
  logic             dmiss_hit;
  logic             issue;
  logic             to_clear;
  logic             to_inc;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_comb begin
    luh       = load_use(bus.ld_ID_EX, bus.ld_dst_ID_EX, bus.src0_IM_ID,
                         bus.src1_IM_ID, bus.src0_vld, bus.src1_vld);
    dmiss_hit = bus.dm_access_EX_DM && !bus.d_rdy;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    ctrl    = CTRL_PASS;
    issue   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dmiss_hit) begin
          ctrl    = CTRL_FREEZE;
          state_d = DMISS;
        end else begin
          issue = 1'b1;
        end
      end
      DMISS: begin
        if (!bus.d_rdy) begin
          ctrl = CTRL_FREEZE;
        end else begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (dmiss_hit) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl = CTRL_DRAIN;
          if (drain_q == '0) begin
            state_d = HALT;
          end else begin
            drain_d = drain_q - DRN_W'(1);
          end
        end
      end
      HALT: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A miss release issues in the same cycle, so a held branch replays here.
    if (issue) begin
      ctrl = run_ctrl(bus.flow_change_ID_EX, bus.hlt_ID_EX, luh, bus.i_rdy);
      if (bus.hlt_ID_EX && !bus.flow_change_ID_EX) begin
        state_d = DRAIN;
        drain_d = DRAIN_LOAD;
      end
    end
  end

  always_comb begin
    to_inc     = (state_q == DMISS);
    to_clear   = (state_q != DMISS) && (state_d == DMISS);
    miss_err_d = miss_err_q || (to_inc && (to_cnt >= TO_LAST));
    ctrl_out   = rst_n ? ctrl : CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      drain_q    <= '0;
      miss_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      miss_err_q <= miss_err_d;
    end
  end

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (to_clear),
    .inc   (to_inc),
    .count (to_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (ctrl.stall_im_id),
    .count (stall_cnt)
  );

  assign bus.stall_IM_ID = ctrl_out.stall_im_id;
  assign bus.stall_ID_EX = ctrl_out.stall_id_ex;
  assign bus.stall_EX_DM = ctrl_out.stall_ex_dm;
  assign bus.flush_IM_ID = ctrl_out.flush_im_id;
  assign bus.flush_ID_EX = ctrl_out.flush_id_ex;
  assign bus.halted      = (state_q == HALT);
  assign bus.miss_err    = miss_err_q;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DRAIN_CYCLES=2, MISS_TIMEOUT=4 and
// a 4-bit stall counter so timeout and saturation are reached quickly.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: {stall_IM_ID, stall_ID_EX, stall_EX_DM, flush_IM_ID, flush_ID_EX}
  localparam logic [4:0] EXP_PASS   = 5'b00000;
  localparam logic [4:0] EXP_FREEZE = 5'b11100;
  localparam logic [4:0] EXP_RESET  = 5'b11111;
  localparam logic [4:0] EXP_SQUASH = 5'b00011;
  localparam logic [4:0] EXP_IDBUB  = 5'b10001;
  localparam logic [4:0] EXP_IFBUB  = 5'b10010;
  localparam logic [4:0] EXP_DRAIN  = 5'b10011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] ctrl_obs;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .DRAIN_CYCLES (2),
    .MISS_TIMEOUT (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {bus.stall_IM_ID, bus.stall_ID_EX, bus.stall_EX_DM,
                     bus.flush_IM_ID, bus.flush_ID_EX};

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [4:0] exp);
    checkOutput(tag, {11'b0, ctrl_obs}, {11'b0, exp});
  endtask

  task automatic checkCnt(input string tag, input logic [3:0] exp);
    checkOutput(tag, {12'b0, bus.stall_cnt}, {12'b0, exp});
  endtask

  task automatic applyStimulus(
    input logic       ir,
    input logic       dr,
    input logic       dm,
    input logic       fl,
    input logic       hl,
    input logic       ld,
    input logic [3:0] dst,
    input logic [3:0] s0,
    input logic [3:0] s1,
    input logic       v0,
    input logic       v1
  );
    bus.i_rdy             = ir;
    bus.d_rdy             = dr;
    bus.dm_access_EX_DM   = dm;
    bus.flow_change_ID_EX = fl;
    bus.hlt_ID_EX         = hl;
    bus.ld_ID_EX          = ld;
    bus.ld_dst_ID_EX      = dst;
    bus.src0_IM_ID        = s0;
    bus.src1_IM_ID        = s1;
    bus.src0_vld          = v0;
    bus.src1_vld          = v1;
    #1;
  endtask

  task automatic setIdle();
    applyStimulus(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setIdle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    // Reset values
    setIdle();
    checkCtrl("reset_ctrl", EXP_RESET);
    checkOutput("reset_halted", {15'b0, bus.halted}, 16'h0);
    checkOutput("reset_miss_err", {15'b0, bus.miss_err}, 16'h0);
    checkCnt("reset_stall_cnt", 4'h0);
    doReset();
    setIdle();
    checkCtrl("idle", EXP_PASS);

    // Load-use hazard variants
    applyStimulus(1, 1, 0, 0, 0, 1, 4'h3, 4'h3, 4'h0, 1, 0);
    checkCtrl("luh_src0", EXP_IDBUB);
    tick();
    setIdle();
    checkCtrl("luh_one_cycle", EXP_PASS);
    checkCnt("luh_cnt", 4'h1);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0);
    checkCtrl("luh_dst_zero", EXP_PASS);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 1, 4'h5, 4'h2, 4'h5, 1, 1);
    checkCtrl("luh_src1", EXP_IDBUB);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 1, 4'h5, 4'h2, 4'h5, 1, 0);
    checkCtrl("luh_src1_unused", EXP_PASS);
    checkCnt("luh_cnt2", 4'h2);
    tick();

    // Flow change overrides load-use, imiss and halt
    applyStimulus(0, 1, 0, 1, 0, 1, 4'h3, 4'h3, 4'h0, 1, 0);
    checkCtrl("branch_over_hazards", EXP_SQUASH);
    tick();
    applyStimulus(1, 1, 0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("branch_over_halt", EXP_SQUASH);
    tick();
    setIdle();
    checkCtrl("no_drain_after_branch", EXP_PASS);
    checkCnt("branch_cnt", 4'h2);
    applyStimulus(0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("imiss", EXP_IFBUB);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 1, 4'h7, 4'h0, 4'h7, 0, 1);
    checkCtrl("luh_over_imiss", EXP_IDBUB);
    tick();
    setIdle();
    checkCnt("imiss_cnt", 4'h4);

    // Data miss with a branch held in EX
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      checkCtrl("dmiss_hold", EXP_FREEZE);
      tick();
    end
    applyStimulus(1, 1, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("dmiss_release_branch", EXP_SQUASH);
    checkCnt("dmiss_cnt", 4'h5);
    checkOutput("dmiss_miss_err", {15'b0, bus.miss_err}, 16'h1);
    tick();
    setIdle();
    checkCtrl("after_dmiss", EXP_PASS);

    // Miss timeout: RUN cycle plus four DMISS cycles before the flag shows
    doReset();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      checkOutput($sformatf("timeout_cyc%0d", i), {15'b0, bus.miss_err},
                  (i >= 6) ? 16'h1 : 16'h0);
      tick();
    end
    applyStimulus(1, 1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("timeout_release", EXP_PASS);
    checkCnt("timeout_cnt", 4'hA);
    tick();
    setIdle();
    checkOutput("miss_err_sticky", {15'b0, bus.miss_err}, 16'h1);
    doReset();
    setIdle();
    checkOutput("miss_err_cleared", {15'b0, bus.miss_err}, 16'h0);

    // Reset in the middle of a miss returns to RUN
    applyStimulus(1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("reset_mid_miss", EXP_PASS);

    // Halt, drain with a frozen counter during a miss, then freeze
    doReset();
    applyStimulus(1, 1, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("halt_issue", EXP_IDBUB);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      checkCtrl("drain_dmiss", EXP_FREEZE);
      tick();
    end
    applyStimulus(1, 1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    checkCtrl("drain1_flow_ignored", EXP_DRAIN);
    checkOutput("drain1_halted", {15'b0, bus.halted}, 16'h0);
    tick();
    setIdle();
    checkCtrl("drain2", EXP_DRAIN);
    checkOutput("drain2_halted", {15'b0, bus.halted}, 16'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      checkCtrl("halt_ctrl", EXP_FREEZE);
      checkOutput("halt_halted", {15'b0, bus.halted}, 16'h1);
      tick();
    end
    rst_n = 1'b0;
    setIdle();
    checkCtrl("halt_reset_ctrl", EXP_RESET);
    checkOutput("halt_reset_halted", {15'b0, bus.halted}, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setIdle();
    checkCtrl("after_halt_reset", EXP_PASS);

    // Instruction miss for 20 cycles saturates the 4-bit stall counter
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
      if (i == 0 || i == 19) checkCtrl("imiss_long", EXP_IFBUB);
      if (i == 14) checkCnt("cnt_before_sat", 4'hE);
      tick();
      if (i == 14) checkCnt("cnt_at_sat", 4'hF);
    end
    setIdle();
    checkCnt("cnt_no_wrap", 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline (IM, ID, EX, DM, WB). It generates the per-stage stall enables consumed by the program counter and the pipeline registers. It also generates bubble/squash controls for the IM_ID and ID_EX registers. Sources it arbitrates: instruction-memory miss, data-memory miss, load-use hazard, taken branch/jump, and halt.

Parameters:
DRAIN_CYCLES, 2, cycles allowed for in-flight instructions to retire after halt reaches EX before freezing
MISS_TIMEOUT, 255, consecutive DMISS cycles before sticky miss_err asserts
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_rdy  in  1  instruction memory has valid data this cycle
d_rdy  in  1  data memory completes access this cycle
dm_access_EX_DM  in  1  load/store in DM stage
ld_ID_EX  in  1  load instruction in EX stage
ld_dst_ID_EX  in  4  destination register of that load
src0_IM_ID  in  4  ID-stage source register 0
src1_IM_ID  in  4  ID-stage source register 1
src0_vld  in  1  src0 used by ID instruction
src1_vld  in  1  src1 used by ID instruction
flow_change_ID_EX  in  1  taken branch/jump resolved in EX
hlt_ID_EX  in  1  halt instruction in EX
stall_IM_ID  out  1  hold PC and IM_ID register
stall_ID_EX  out  1  hold ID_EX register
stall_EX_DM  out  1  hold EX_DM register
flush_IM_ID  out  1  load NOP into IM_ID
flush_ID_EX  out  1  load NOP into ID_EX
halted  out  1  pipeline frozen by halt
miss_err  out  1  sticky DMISS timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with stall_IM_ID=1

Behaviour:
- Reset is asynchronous, active-low, on clock clk. While rst_n=0, all stall_* and flush_* outputs are 1. halted=0, miss_err=0, stall_cnt=0, state=RUN.
- FSM states: RUN, DMISS, DRAIN, HALT. The state is registered. Outputs are combinational from state plus the current inputs.
- Load-use hazard: luh = ld_ID_EX & (ld_dst_ID_EX!=0) & ((src0_vld & src0_IM_ID==ld_dst_ID_EX) | (src1_vld & src1_IM_ID==ld_dst_ID_EX)).
- RUN priority, highest first:
  1. dm_access_EX_DM & !d_rdy: all three stalls=1, no flush, next=DMISS.
  2. flow_change_ID_EX: stalls=0, flush_IM_ID=1, flush_ID_EX=1. This squashes the two younger instructions and lets the PC load the target. It overrides luh and !i_rdy.
  3. hlt_ID_EX: stall_IM_ID=1, flush_ID_EX=1, next=DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  4. luh: stall_IM_ID=1, flush_ID_EX=1 (one bubble), stall_ID_EX=0, stall_EX_DM=0.
  5. !i_rdy: stall_IM_ID=1, flush_IM_ID=1, later stages advance.
  6. Otherwise all outputs 0.
- DMISS: all stalls=1 and flushes=0 while d_rdy=0. In the cycle d_rdy=1, all stalls=0 and RUN-priority evaluation resumes in that same cycle, minus rule 1. next=RUN.
  - A branch held in EX during DMISS replays its flow change on release.
  - The timeout counter increments each DMISS cycle. When it reaches MISS_TIMEOUT, miss_err sets and stays set until reset. The stall continues regardless. The counter clears on entry to DMISS.
- DRAIN: stall_IM_ID=1, flush_IM_ID=1, flush_ID_EX=1, later stages advance. The counter decrements each cycle; when it is 0, next=HALT.
  - A DMISS during DRAIN stalls all stages and freezes the counter.
  - flow_change is ignored in DRAIN.
- HALT: all stalls=1, flushes=0, halted=1. The only exit is reset.
- stall_cnt increments when stall_IM_ID=1 and rst_n=1, and saturates at all-ones.
- Reset mid-miss or mid-drain returns to RUN immediately. Counters clear.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encoding (2-bit enum RUN=0, DMISS=1, DRAIN=2, HALT=3), the NOP-related constants, and the REG_ZERO=4'h0 constant.
- One natural sub-module: sat_counter (parameterised width, inc, clear). It is reused for stall_cnt and the DMISS timeout.

Test Plan:
- Load-use: ld_ID_EX=1, ld_dst=4'h3, src0_IM_ID=4'h3, src0_vld=1 for one cycle -> stall_IM_ID=1, flush_ID_EX=1 for exactly 1 cycle, stall_EX_DM=0. Same stimulus with ld_dst=0 -> no stall.
- Branch vs hazards: flow_change_ID_EX=1 with luh=1 and i_rdy=0 in the same cycle -> all stalls 0, flush_IM_ID=1, flush_ID_EX=1.
- DMISS: dm_access=1, d_rdy=0 for 5 cycles, with flow_change=1 held -> all stalls 1 for 5 cycles; on the d_rdy=1 cycle stalls=0 and both flushes=1. stall_cnt advances by 5.
- Timeout: MISS_TIMEOUT=4, d_rdy=0 for 10 cycles -> miss_err rises after the 4th DMISS cycle, remains 1 after d_rdy, clears only on rst_n pulse.
- Halt: hlt_ID_EX=1 with DRAIN_CYCLES=2 -> 2 DRAIN cycles, then halted=1 with all stalls 1 indefinitely. rst_n low for 1 cycle -> halted=0, state RUN.
- Imiss plus counter saturation: CNT_W=4, i_rdy=0 for 20 cycles -> stall_IM_ID=1, flush_IM_ID=1, stall_ID_EX=0, and stall_cnt=4'hF with no wrap.
